// File: rtl/demux_frame_scheduler.sv
// -----------------------------------------------------------------------------
// demux_frame_scheduler
//
// Upstream sequencer for a 1:16 demultiplexer. Accepts a 16-bit data word and a
// 16-bit channel mask through a valid/ready handshake. It then walks the set mask
// bits from the lowest channel to the highest, one channel per clock. For each
// channel it drives the demux Enable/Select/Data lines. An optional idle gap
// follows each frame. Each completed frame produces a one-cycle done pulse and
// increments a wrapping 8-bit counter.
//
// Parameters
//   GAP_CYCLES        idle cycles after each frame before the next accept (0..15)
//
// Ports
//   Clock_In          clock, rising edge active
//   Reset_n_In        asynchronous active-low reset
//   Abort_In          synchronous abort back to IDLE (no done, count unchanged)
//   Frame_Valid_In    frame offered
//   Frame_Ready_Out   frame can be accepted this cycle
//   Frame_Data_In     bit i = value for demux channel i
//   Frame_Mask_In     bit i = 1 -> channel i driven this frame
//   Demux_Enable_Out  demux Enable_In
//   Demux_Select_Out  demux Select_In (holds last driven channel when idle)
//   Demux_Data_Out    demux Data_In
//   Busy_Out          high while scanning or in the inter-frame gap
//   Frame_Done_Out    one-cycle pulse per completed frame
//   Frames_Sent_Out   completed-frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module demux_frame_scheduler #(
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        Clock_In,
   input  logic        Reset_n_In,
   input  logic        Abort_In,
   input  logic        Frame_Valid_In,
   output logic        Frame_Ready_Out,
   input  logic [15:0] Frame_Data_In,
   input  logic [15:0] Frame_Mask_In,
   output logic        Demux_Enable_Out,
   output logic [3:0]  Demux_Select_Out,
   output logic        Demux_Data_Out,
   output logic        Busy_Out,
   output logic        Frame_Done_Out,
   output logic [7:0]  Frames_Sent_Out
);

   localparam logic [3:0] GAP_W = 4'(GAP_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_data;
   logic [15:0] r_remaining;
   logic [3:0]  r_gap_cnt;
   logic [7:0]  r_frames;
   logic        r_done;
   logic [3:0]  r_sel_hold;

   logic [3:0]  w_low_idx;
   logic        w_last_bit;
   logic        w_accept;
   logic        w_complete;

   // Lowest set bit of the remaining mask. The loop runs downwards so the
   // lowest index is the last one written.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_low_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (r_remaining[i]) w_low_idx = 4'(i);
      end
   end

   // True when only one bit is left, so this SCAN cycle is the final one.
   assign w_last_bit = ((r_remaining & (r_remaining - 16'd1)) == 16'd0);

   assign w_accept   = (r_state == ST_IDLE) && Frame_Valid_In && !Abort_In;

   // A zero-mask frame completes on its acceptance edge. A normal frame completes
   // on the edge that clears its last bit. Abort suppresses both cases.
   assign w_complete = !Abort_In &&
                       ((w_accept && (Frame_Mask_In == 16'd0)) ||
                        ((r_state == ST_SCAN) && w_last_bit));

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_remaining <= '0;
         r_gap_cnt   <= '0;
         r_frames    <= '0;
         r_done      <= 1'b0;
         r_sel_hold  <= '0;
      end else begin
         r_done <= w_complete;

         if (w_complete) r_frames <= r_frames + 8'd1;

         // Select keeps the last channel actually presented, including one
         // presented in the cycle an abort hits.
         if (r_state == ST_SCAN) r_sel_hold <= w_low_idx;

         if (Abort_In) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_data      <= Frame_Data_In;
                     r_remaining <= Frame_Mask_In;
                     if (Frame_Mask_In != 16'd0) begin
                        r_state <= ST_SCAN;
                     end else if (GAP_W != 4'd0) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_W;
                     end
                  end
               end

               ST_SCAN: begin
                  r_remaining <= r_remaining & (r_remaining - 16'd1);
                  if (w_last_bit) begin
                     if (GAP_W != 4'd0) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_W;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end

               ST_GAP: begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
                  if (r_gap_cnt == 4'd1) r_state <= ST_IDLE;
               end

               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Reset is included in Ready so that no frame is offered a handshake while
   // the block is held in reset.
   assign Frame_Ready_Out  = Reset_n_In && (r_state == ST_IDLE) && !Abort_In;
   assign Demux_Enable_Out = (r_state == ST_SCAN);
   assign Demux_Select_Out = (r_state == ST_SCAN) ? w_low_idx : r_sel_hold;
   assign Demux_Data_Out   = (r_state == ST_SCAN) ? r_data[w_low_idx] : 1'b0;
   assign Busy_Out         = (r_state == ST_SCAN) || (r_state == ST_GAP);
   assign Frame_Done_Out   = r_done;
   assign Frames_Sent_Out  = r_frames;

endmodule

// File: tb/tb_demux_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for demux_frame_scheduler. Two instances share the stimulus:
// instance 0 has GAP_CYCLES=0 and instance 1 has GAP_CYCLES=1. Each instance is
// compared every cycle against a schedule model. On acceptance, the model
// expands a frame into the list of per-cycle outputs it should produce.
// -----------------------------------------------------------------------------
module tb_demux_frame_scheduler;

   logic        clk;
   logic        rst_n;
   logic        abort;
   logic        valid;
   logic [15:0] fdata;
   logic [15:0] fmask;

   logic [1:0]      rdy;
   logic [1:0]      en;
   logic [1:0][3:0] sel;
   logic [1:0]      dat;
   logic [1:0]      busy;
   logic [1:0]      done;
   logic [1:0][7:0] frames;

   demux_frame_scheduler #(.GAP_CYCLES(0)) dut0 (
      .Clock_In         (clk),
      .Reset_n_In       (rst_n),
      .Abort_In         (abort),
      .Frame_Valid_In   (valid),
      .Frame_Ready_Out  (rdy[0]),
      .Frame_Data_In    (fdata),
      .Frame_Mask_In    (fmask),
      .Demux_Enable_Out (en[0]),
      .Demux_Select_Out (sel[0]),
      .Demux_Data_Out   (dat[0]),
      .Busy_Out         (busy[0]),
      .Frame_Done_Out   (done[0]),
      .Frames_Sent_Out  (frames[0])
   );

   demux_frame_scheduler #(.GAP_CYCLES(1)) dut1 (
      .Clock_In         (clk),
      .Reset_n_In       (rst_n),
      .Abort_In         (abort),
      .Frame_Valid_In   (valid),
      .Frame_Ready_Out  (rdy[1]),
      .Frame_Data_In    (fdata),
      .Frame_Mask_In    (fmask),
      .Demux_Enable_Out (en[1]),
      .Demux_Select_Out (sel[1]),
      .Demux_Data_Out   (dat[1]),
      .Busy_Out         (busy[1]),
      .Frame_Done_Out   (done[1]),
      .Frames_Sent_Out  (frames[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One expected output cycle. rdy is the Ready value before abort masking.
   typedef struct packed {
      logic       en;
      logic [3:0] sel;
      logic       dat;
      logic       done;
      logic       busy;
      logic       rdy;
   } exp_t;

   exp_t       q [2][$];
   logic [3:0] last_sel [2];
   logic [7:0] cnt [2];
   int         checks;
   int         failures;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t idle_entry();
      exp_t e;
      e = '{en: 1'b0, sel: 4'd0, dat: 1'b0, done: 1'b0, busy: 1'b0, rdy: 1'b1};
      return e;
   endfunction

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : 1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         q[k].delete();
         last_sel[k] = 4'd0;
         cnt[k]      = 8'd0;
      end
   endtask

   // Expand an accepted frame into its cycle-by-cycle schedule.
   task automatic build_frame(input int k, input logic [15:0] d, input logic [15:0] m);
      int g;
      g = gap_of(k);
      for (int i = 0; i < 16; i++) begin
         if (m[i]) q[k].push_back('{1'b1, 4'(i), d[i], 1'b0, 1'b1, 1'b0});
      end
      q[k].push_back('{1'b0, 4'd0, 1'b0, 1'b1, (g != 0), (g == 0)});
      for (int i = 1; i < g; i++) q[k].push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
   endtask

   task automatic check_outputs();
      exp_t cur;
      for (int k = 0; k < 2; k++) begin
         cur = (q[k].size() > 0) ? q[k][0] : idle_entry();
         check($sformatf("dut%0d enable", k), 16'(en[k]),   16'(cur.en));
         check($sformatf("dut%0d select", k), 16'(sel[k]),  16'(cur.en ? cur.sel : last_sel[k]));
         check($sformatf("dut%0d data",   k), 16'(dat[k]),  16'(cur.en ? cur.dat : 1'b0));
         check($sformatf("dut%0d done",   k), 16'(done[k]), 16'(cur.done));
         check($sformatf("dut%0d busy",   k), 16'(busy[k]), 16'(cur.busy));
         check($sformatf("dut%0d ready",  k), 16'(rdy[k]),  16'(cur.rdy && !abort));
         check($sformatf("dut%0d frames", k), 16'(frames[k]), 16'(cnt[k]));
      end
   endtask

   task automatic model_edge();
      exp_t cur;
      for (int k = 0; k < 2; k++) begin
         cur = (q[k].size() > 0) ? q[k][0] : idle_entry();
         if (cur.en) last_sel[k] = cur.sel;
         if (abort) begin
            q[k].delete();
         end else if (cur.rdy && valid) begin
            q[k].delete();
            build_frame(k, fdata, fmask);
         end else if (q[k].size() > 0) begin
            void'(q[k].pop_front());
         end
         if (!abort && (q[k].size() > 0) && q[k][0].done) cnt[k] = cnt[k] + 8'd1;
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic [15:0] m, input logic a);
      @(negedge clk);
      valid = v;
      fdata = d;
      fmask = m;
      abort = a;
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 16'($urandom), 1'b0);
   endtask

   task automatic check_reset_values();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("dut%0d rst enable", k), 16'(en[k]),     16'd0);
         check($sformatf("dut%0d rst select", k), 16'(sel[k]),    16'd0);
         check($sformatf("dut%0d rst data",   k), 16'(dat[k]),    16'd0);
         check($sformatf("dut%0d rst busy",   k), 16'(busy[k]),   16'd0);
         check($sformatf("dut%0d rst done",   k), 16'(done[k]),   16'd0);
         check($sformatf("dut%0d rst frames", k), 16'(frames[k]), 16'd0);
         check($sformatf("dut%0d rst ready",  k), 16'(rdy[k]),    16'd0);
      end
   endtask

   logic [7:0] cnt_start;
   logic [15:0] m_r;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      abort    = 1'b0;
      valid    = 1'b1;
      fdata    = 16'h0;
      fmask    = 16'h0;
      model_reset();
      #1;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b1;

      // Full mask: 16 channels in ascending order, data LSB first.
      idle_steps(2);
      step(1'b1, 16'hA5C3, 16'hFFFF, 1'b0);
      idle_steps(20);

      // Sparse mask: channels 0, 8, 15.
      step(1'b1, 16'h8001, 16'h8101, 1'b0);
      idle_steps(6);

      // Zero mask: done pulse only.
      step(1'b1, 16'h1234, 16'h0000, 1'b0);
      idle_steps(4);

      // Back-to-back frames on the gap-free instance, 256 frames to wrap the counter.
      cnt_start = cnt[0];
      for (int i = 0; i < 768; i++) step(1'b1, 16'($urandom), 16'h0003, 1'b0);
      #1;
      check("dut0 frames wrap", 16'(frames[0]), 16'(cnt_start));
      idle_steps(4);

      // Abort during the 5th scan cycle, then abort together with valid in IDLE.
      step(1'b1, 16'h5A5A, 16'hFFFF, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b1);
      idle_steps(3);
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      idle_steps(3);

      // Asynchronous reset in the middle of a scan, away from any clock edge.
      step(1'b1, 16'hC3C3, 16'hF0F0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b0);
      #2;
      valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      check_reset_values();
      valid = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 16'h00FF, 16'h0181, 1'b0);
      idle_steps(5);

      // Randomized traffic with occasional aborts and varied mask densities.
      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 7))
            0:       m_r = 16'h0000;
            1:       m_r = 16'h0001 << $urandom_range(0, 15);
            2:       m_r = 16'hFFFF;
            default: m_r = 16'($urandom);
         endcase
         step(1'($urandom_range(0, 1)), 16'($urandom), m_r, ($urandom_range(0, 31) == 0));
      end
      idle_steps(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
